// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter that shares one slave port between NUM_MST masters.
// A master holds the grant for a single transfer, then priority moves to the next index.
// A watchdog aborts a granted transfer that the slave never accepts.
//
// state | meaning
// IDLE  | no grant; the next requester is picked from rr_ptr upward
// BUSY  | one master granted; its request is forwarded to the slave
module bus_rr_arbiter #(
    parameter int NUM_MST = 2,
    parameter int AW      = 4,
    parameter int DW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_MST-1:0]    mst_valid,
    input  logic [NUM_MST*AW-1:0] mst_addr,
    input  logic [NUM_MST*DW-1:0] mst_wdata,
    output logic [NUM_MST*DW-1:0] mst_rdata,
    output logic [NUM_MST-1:0]    mst_ready,
    output logic                  slv_valid,
    output logic [AW-1:0]         slv_addr,
    output logic [DW-1:0]         slv_wdata,
    input  logic [DW-1:0]         slv_rdata,
    input  logic                  slv_ready,
    output logic [NUM_MST-1:0]    grant,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int IW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state_q;
    logic [NUM_MST-1:0] grant_q;
    logic [IW-1:0]      rr_ptr_q;
    logic [CW-1:0]      wait_cnt_q;
    logic               timeout_err_q;

    logic [IW-1:0]      gidx;
    logic [IW-1:0]      pick_idx;
    logic               pick_found;
    logic [NUM_MST-1:0] req_rot;
    logic [IW-1:0]      ptr_adv_d;
    logic               g_valid;
    logic               hs;

    // Index of the granted master, decoded from the one-hot grant register.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (grant_q[i]) gidx = IW'(i);
        end
    end

    // Requests rotated so bit 0 is the master at rr_ptr; the first set bit wins.
    always_comb begin
        req_rot    = NUM_MST'({mst_valid, mst_valid} >> rr_ptr_q);
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        for (int k = 0; k < NUM_MST; k++) begin
            if (!pick_found && req_rot[k]) begin
                pick_found = 1'b1;
                pick_idx   = IW'((int'(rr_ptr_q) + k) % NUM_MST);
            end
        end
    end

    assign ptr_adv_d = (gidx == IW'(NUM_MST - 1)) ? '0 : gidx + 1'b1;
    assign g_valid   = mst_valid[gidx];
    assign hs        = (state_q == ST_BUSY) && g_valid && slv_ready;

    // Forward the granted master to the slave and route the response back to it alone.
    always_comb begin
        slv_valid = 1'b0;
        slv_addr  = '0;
        slv_wdata = '0;
        mst_ready = '0;
        mst_rdata = '0;
        if (state_q == ST_BUSY) begin
            slv_valid                   = g_valid;
            slv_addr                    = mst_addr[gidx*AW +: AW];
            slv_wdata                   = mst_wdata[gidx*DW +: DW];
            mst_ready[gidx]             = slv_ready & g_valid;
            mst_rdata[gidx*DW +: DW]    = slv_rdata;
        end
    end

    // Arbitration FSM: grant, round-robin pointer, watchdog and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    wait_cnt_q <= '0;
                    if (pick_found) begin
                        grant_q <= NUM_MST'(1) << pick_idx;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A withdrawn request ends the transfer like a handshake, minus the error.
                    if (hs || !g_valid) begin
                        state_q    <= ST_IDLE;
                        grant_q    <= '0;
                        rr_ptr_q   <= ptr_adv_d;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                        state_q       <= ST_IDLE;
                        grant_q       <= '0;
                        rr_ptr_q      <= ptr_adv_d;
                        wait_cnt_q    <= '0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign busy        = (state_q == ST_BUSY);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed scenarios push expected slave-port events
// into a scoreboard; a negedge monitor pops and compares on each mst_ready or timeout_err.
module tb_bus_rr_arbiter;

    localparam int NM = 2;
    localparam int AW = 4;
    localparam int DW = 4;
    localparam int TO = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NM-1:0]    mst_valid;
    logic [NM*AW-1:0] mst_addr;
    logic [NM*DW-1:0] mst_wdata;
    logic [NM*DW-1:0] mst_rdata;
    logic [NM-1:0]    mst_ready;
    logic             slv_valid;
    logic [AW-1:0]    slv_addr;
    logic [DW-1:0]    slv_wdata;
    logic [DW-1:0]    slv_rdata;
    logic             slv_ready;
    logic [NM-1:0]    grant;
    logic             busy;
    logic             timeout_err;

    logic             slv_en;
    logic [DW-1:0]    rd_mask;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit         is_to;
        int         m;
        logic [3:0] a;
        logic [3:0] w;
        logic [3:0] r;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    // Slave model: accepts only while enabled and only a valid request; returns wdata ^ rd_mask.
    assign slv_ready = slv_en & slv_valid;
    assign slv_rdata = slv_wdata ^ rd_mask;

    bus_rr_arbiter #(
        .NUM_MST(NM),
        .AW(AW),
        .DW(DW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mst_valid(mst_valid),
        .mst_addr(mst_addr),
        .mst_wdata(mst_wdata),
        .mst_rdata(mst_rdata),
        .mst_ready(mst_ready),
        .slv_valid(slv_valid),
        .slv_addr(slv_addr),
        .slv_wdata(slv_wdata),
        .slv_rdata(slv_rdata),
        .slv_ready(slv_ready),
        .grant(grant),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_xfer(input int m, input logic [3:0] a, input logic [3:0] w);
        exp_t x;
        x.is_to = 1'b0;
        x.m     = m;
        x.a     = a;
        x.w     = w;
        x.r     = w ^ rd_mask;
        sb.push_back(x);
    endtask

    task automatic push_timeout();
        exp_t x;
        x.is_to = 1'b1;
        x.m     = 0;
        x.a     = '0;
        x.w     = '0;
        x.r     = '0;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mst_valid = '0;
        slv_en    = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_slv_valid", 32'(slv_valid), 0);
        chk("rst_outputs", {slv_addr, slv_wdata, mst_ready, mst_rdata, timeout_err}, 0);
        tick();
        rst_n = 1'b1;
    endtask

    // Monitor: every mst_ready strobe or timeout pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (mst_ready !== '0 || timeout_err !== 1'b0)) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", 32'({mst_ready, timeout_err}), 0);
            end else begin
                e = sb.pop_front();
                if (e.is_to) begin
                    chk("timeout_event", 32'({mst_ready, timeout_err}), 32'b001);
                end else begin
                    chk("xfer_ready", 32'({mst_ready, timeout_err}), 32'(2 << e.m));
                    chk("xfer_slv_addr", 32'(slv_addr), 32'(e.a));
                    chk("xfer_slv_wdata", 32'(slv_wdata), 32'(e.w));
                    chk("xfer_rdata", 32'(mst_rdata), 32'(e.r) << (e.m * DW));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NM-1:0] exp_g;
        rst_n     = 1'b0;
        mst_valid = '0;
        mst_addr  = '0;
        mst_wdata = '0;
        slv_en    = 1'b0;
        rd_mask   = 4'h0;

        // Single requester, echoing slave, always ready.
        do_reset();
        mst_valid = 2'b01;
        mst_addr  = 8'h0C;
        mst_wdata = 8'h05;
        slv_en    = 1'b1;
        push_xfer(0, 4'hC, 4'h5);
        tick();
        chk("t1_grant", 32'(grant), 32'b01);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_slv_valid", 32'(slv_valid), 1);
        @(negedge clk);
        #1;
        mst_valid = 2'b00;
        tick();
        chk("t1_idle_grant", 32'(grant), 0);
        chk("t1_idle_busy", 32'(busy), 0);

        // Contention: both masters request continuously; grants alternate starting at 0.
        rd_mask = 4'hF;
        do_reset();
        mst_addr  = {4'h3, 4'h1};
        mst_wdata = {4'h4, 4'h2};
        mst_valid = 2'b11;
        slv_en    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push_xfer(0, 4'h1, 4'h2);
            else            push_xfer(1, 4'h3, 4'h4);
        end
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            chk("t2_grant", 32'(grant), 32'(exp_g));
            tick();
            chk("t2_idle", 32'(busy), 0);
        end
        mst_valid = 2'b00;

        // Slow slave: ready arrives in the 4th busy cycle, the last one before the watchdog fires.
        do_reset();
        mst_addr  = {4'h9, 4'h7};
        mst_wdata = {4'h6, 4'hA};
        mst_valid = 2'b11;
        slv_en    = 1'b0;
        push_xfer(0, 4'h7, 4'hA);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_busy", 32'(busy), 1);
            chk("t3_grant", 32'(grant), 32'b01);
        end
        slv_en = 1'b1;
        tick();
        chk("t3_done_busy", 32'(busy), 0);
        chk("t3_done_err", 32'(timeout_err), 0);
        mst_valid = 2'b00;
        slv_en    = 1'b0;

        // Timeout: slave never ready for master 0; master 1 is served next.
        do_reset();
        mst_addr  = {4'hB, 4'h2};
        mst_wdata = {4'hD, 4'hE};
        mst_valid = 2'b11;
        slv_en    = 1'b0;
        push_timeout();
        for (int i = 0; i < TO; i++) begin
            tick();
            chk("t4_busy", 32'(busy), 1);
            chk("t4_grant", 32'(grant), 32'b01);
        end
        tick();
        chk("t4_abort_busy", 32'(busy), 0);
        chk("t4_abort_err", 32'(timeout_err), 1);
        push_xfer(1, 4'hB, 4'hD);
        slv_en = 1'b1;
        tick();
        chk("t4_next_grant", 32'(grant), 32'b10);
        chk("t4_err_cleared", 32'(timeout_err), 0);
        tick();
        chk("t4_done_busy", 32'(busy), 0);
        mst_valid = 2'b00;
        slv_en    = 1'b0;

        // Withdrawn request from master 1: silent return to IDLE, pointer back at 0.
        do_reset();
        mst_valid = 2'b10;
        tick();
        chk("t5_grant", 32'(grant), 32'b10);
        tick();
        chk("t5_still_busy", 32'(busy), 1);
        mst_valid = 2'b00;
        tick();
        chk("t5_idle_busy", 32'(busy), 0);
        chk("t5_no_err", 32'(timeout_err), 0);
        mst_valid = 2'b11;
        tick();
        chk("t5_ptr_grant", 32'(grant), 32'b01);
        mst_valid = 2'b00;
        tick();
        chk("t5_withdraw_idle", 32'(busy), 0);

        // Async reset while master 1 is stalled in BUSY.
        do_reset();
        mst_addr  = {4'h5, 4'h8};
        mst_wdata = {4'h1, 4'h3};
        mst_valid = 2'b10;
        slv_en    = 1'b0;
        tick();
        chk("t6_grant", 32'(grant), 32'b10);
        tick();
        chk("t6_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_grant", 32'(grant), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_slv_valid", 32'(slv_valid), 0);
        tick();
        rst_n     = 1'b1;
        mst_valid = 2'b11;
        slv_en    = 1'b1;
        push_xfer(0, 4'h8, 4'h3);
        tick();
        chk("t6_first_grant", 32'(grant), 32'b01);
        tick();
        chk("t6_done_busy", 32'(busy), 0);
        mst_valid = 2'b00;
        slv_en    = 1'b0;

        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Round-robin arbiter that shares one slave port (valid/addr/wdata/rdata/ready bus) between NUM_MST master ports.
- Sits between the master and slave instances in an aggregate.
- Holds the grant for exactly one transfer, then rotates priority.
- Aborts a transfer that the slave never accepts, using a watchdog counter.

Parameters:
NUM_MST, 2, number of requesting masters (2..8)
AW, 4, address width
DW, 4, data width (wdata and rdata)
TIMEOUT, 15, cycles a granted transfer may wait for slv_ready before abort (1..255)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
mst_valid  input  NUM_MST  per-master request/valid, bit i = master i
mst_addr  input  NUM_MST*AW  master i address at bits [i*AW +: AW]
mst_wdata  input  NUM_MST*DW  master i write data at bits [i*DW +: DW]
mst_rdata  output  NUM_MST*DW  read data, routed to granted master only
mst_ready  output  NUM_MST  transfer-complete strobe per master
slv_valid  output  1  valid to shared slave
slv_addr  output  AW  address to slave
slv_wdata  output  DW  write data to slave
slv_rdata  input  DW  read data from slave
slv_ready  input  1  slave accept
grant  output  NUM_MST  one-hot registered grant, 0 when idle
busy  output  1  high in BUSY state
timeout_err  output  1  one-cycle pulse after an aborted transfer

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, grant=0, rr_ptr=0, wait_cnt=0, timeout_err=0.
  - All outputs 0: slv_valid=0, slv_addr=0, slv_wdata=0, mst_ready=0, mst_rdata=0, busy=0.
- State IDLE:
  - slv_valid=0; all mst_ready=0.
  - If any mst_valid bit is set, select the first set bit at or after rr_ptr, searching upward with wrap modulo NUM_MST.
  - Register grant one-hot; next state BUSY.
  - Arbitration latency is 1 cycle: the request seen in cycle N is forwarded to the slave in cycle N+1.
- State BUSY, granted index g:
  - Combinational forwarding:
    - slv_valid = mst_valid[g]; slv_addr and slv_wdata = master g fields.
    - mst_ready[g] = slv_ready & mst_valid[g]; mst_rdata slice g = slv_rdata.
    - All other mst_ready = 0 and other rdata slices = 0.
  - Handshake (slv_valid & slv_ready):
    - Transfer done; next state IDLE.
    - rr_ptr = (g+1) mod NUM_MST; grant=0; wait_cnt=0.
  - Master g drops mst_valid before handshake (protocol violation):
    - Next state IDLE, rr_ptr = (g+1) mod NUM_MST.
    - No error pulse.
  - Otherwise (waiting):
    - wait_cnt increments by 1.
    - When wait_cnt == TIMEOUT-1 and there is no handshake this cycle: next state IDLE, rr_ptr advances as above, timeout_err=1 in the next cycle only, wait_cnt cleared.
    - Master g sees no mst_ready for the aborted transfer.
- Minimum transfer spacing: a master gets at most one transfer per 2 cycles (IDLE, BUSY). Back-to-back requests from the same master alternate with others when others are pending.
- The slave must not be asserting slv_ready while slv_valid=0; the arbiter ignores slv_ready in IDLE.
- wait_cnt width is ceil(log2(TIMEOUT+1)) and never wraps; it clears on entry to IDLE.
- mst_addr and mst_wdata of non-granted masters have no effect.
- Reset asserted mid-transfer: immediate return to the reset state; the in-flight transfer is dropped silently (no mst_ready, no timeout_err).
- busy = (state==BUSY). grant is held stable for the whole BUSY period.

Test Plan:
- Single requester: mst_valid=2'b01, addr=4'hC, wdata=4'h5, slave echoes rdata with ready=1 → grant=01 one cycle later; slv_addr=C, slv_wdata=5; mst_ready[0]=1 and rdata slice0=5 in that cycle; then IDLE.
- Contention fairness: both masters hold valid for 8 cycles, slave always ready → grants alternate 01,10,01,10 (rr_ptr starts 0); 4 completed transfers.
- Slow slave: slv_ready asserted 3 cycles after slv_valid → mst_ready[g] pulses exactly once; other master's mst_ready stays 0; busy is high 4 cycles.
- Timeout: TIMEOUT=4, slave never ready → BUSY for 4 cycles, then IDLE; timeout_err=1 for exactly one cycle; next grant goes to the other master if it is requesting.
- Valid withdrawn: master 1 granted, drops valid after 1 cycle → return to IDLE, no mst_ready, no timeout_err, rr_ptr=0.
- Async reset mid-BUSY: rst_n low for 1 cycle while the slave is stalled → grant=0, busy=0, slv_valid=0 immediately; after release, the first grant goes to master 0.
